// File: rtl/bpuf_pkg.sv
// Shared types and constants for the PUF CRP collector.
// Holds the FSM state encoding and the default LFSR geometry.
package bpuf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  localparam int CHAL_W_DEF = 10;

  // x^10 + x^7 + 1: feedback from bits 9 and 6
  localparam int LFSR_TAP_A = 9;
  localparam int LFSR_TAP_B = 6;

endpackage

// File: rtl/bpuf_chal_lfsr.sv
// Fibonacci LFSR that generates the challenge sequence.
// load wins over step; value holds when neither is set.
module bpuf_chal_lfsr
  import bpuf_pkg::*;
#(
  parameter int W     = CHAL_W_DEF,
  parameter int TAP_A = LFSR_TAP_A,
  parameter int TAP_B = LFSR_TAP_B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         step,
  output logic [W-1:0] value
);

  logic [W-1:0] value_q;
  logic [W-1:0] value_d;

  always_comb begin
    value_d = value_q;
    if (load) begin
      value_d = load_val;
    end else if (step) begin
      value_d = {value_q[W-2:0],
                 value_q[TAP_A] ^ value_q[TAP_B]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/bpuf_crp_collector.sv
// Drives PUF challenges, majority-votes synchronized responses
// and offers each challenge/response pair on a valid/ready port.
module bpuf_crp_collector
  import bpuf_pkg::*;
#(
  parameter int CHAL_W        = CHAL_W_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int NUM_SAMPLES   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] seed,
  input  logic [15:0]       num_chal,
  output logic [CHAL_W-1:0] chal,
  input  logic              puf_resp,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CHAL_W-1:0] crp_chal,
  output logic              crp_resp,
  output logic              crp_stable,
  output logic              busy,
  output logic              done
);

  localparam int ONES_W  = $clog2(NUM_SAMPLES + 1);
  localparam int CNT_MAX = (SETTLE_CYCLES > NUM_SAMPLES) ?
                           SETTLE_CYCLES : NUM_SAMPLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0]  SETTLE_LAST =
    CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SAMPLE_LAST =
    CNT_W'(NUM_SAMPLES - 1);
  localparam logic [ONES_W-1:0] HALF = ONES_W'(NUM_SAMPLES / 2);
  localparam logic [ONES_W-1:0] ALL  = ONES_W'(NUM_SAMPLES);

  state_t              state_q, state_d;
  logic [1:0]          sync_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ONES_W-1:0]   ones_q, ones_d;
  logic [15:0]         rem_q, rem_d;
  logic [CHAL_W-1:0]   crp_chal_q;
  logic                crp_resp_q;
  logic                crp_stable_q;
  logic                lfsr_load;
  logic                lfsr_step;
  logic                cap;
  logic                resp_d;
  logic                stable_d;
  logic [CHAL_W-1:0]   load_val;

  // An all-zero seed would lock the LFSR
  assign load_val = (seed == '0) ? CHAL_W'(1) : seed;

  bpuf_chal_lfsr #(
    .W     (CHAL_W),
    .TAP_A (LFSR_TAP_A),
    .TAP_B (LFSR_TAP_B)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (lfsr_load),
    .load_val (load_val),
    .step     (lfsr_step),
    .value    (chal)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], puf_resp};
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ones_d    = ones_q;
    rem_d     = rem_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    cap       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (num_chal != '0) begin
            rem_d     = num_chal;
            lfsr_load = 1'b1;
            cnt_d     = '0;
            ones_d    = '0;
            state_d   = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SAMPLE: begin
        ones_d = ones_q + ONES_W'(sync_q[1]);
        if (cnt_q == SAMPLE_LAST) begin
          cnt_d   = '0;
          cap     = 1'b1;
          state_d = EMIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EMIT: begin
        if (crp_ready) begin
          if (rem_q > 16'd1) begin
            rem_d     = rem_q - 16'd1;
            lfsr_step = 1'b1;
            ones_d    = '0;
            state_d   = SETTLE;
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // abort beats everything, including a same-edge handshake
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      cnt_d     = '0;
      ones_d    = '0;
      lfsr_load = 1'b0;
      lfsr_step = 1'b0;
      cap       = 1'b0;
    end
    resp_d   = ones_d > HALF;
    stable_d = (ones_d == '0) || (ones_d == ALL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ones_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ones_q  <= ones_d;
      rem_q   <= rem_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crp_chal_q   <= '0;
      crp_resp_q   <= 1'b0;
      crp_stable_q <= 1'b0;
    end else if (cap) begin
      crp_chal_q   <= chal;
      crp_resp_q   <= resp_d;
      crp_stable_q <= stable_d;
    end
  end

  assign crp_valid  = (state_q == EMIT);
  assign crp_chal   = crp_chal_q;
  assign crp_resp   = crp_resp_q;
  assign crp_stable = crp_stable_q;
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_bpuf_crp_collector.sv
// Directed bench for bpuf_crp_collector (default parameters).
// Expected values are hand-derived constants.
module tb_bpuf_crp_collector;

  localparam int W = 10;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] seed = '0;
  logic [15:0]  num_chal = '0;
  logic [W-1:0] chal;
  logic         puf_resp = 1'b0;
  logic         crp_valid;
  logic         crp_ready = 1'b0;
  logic [W-1:0] crp_chal;
  logic         crp_resp;
  logic         crp_stable;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  bpuf_crp_collector dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .seed       (seed),
    .num_chal   (num_chal),
    .chal       (chal),
    .puf_resp   (puf_resp),
    .crp_valid  (crp_valid),
    .crp_ready  (crp_ready),
    .crp_chal   (crp_chal),
    .crp_resp   (crp_resp),
    .crp_stable (crp_stable),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done) done_cnt++;

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(logic [W-1:0] s, logic [15:0] n);
    seed = s;
    num_chal = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!crp_valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  logic [W-1:0] exp_chal [3];
  logic [6:0]   pats [4];
  logic [1:0]   exp_rs [4];
  logic [6:0]   pat;
  int           n;
  int           d0;
  int           bad;

  initial begin
    exp_chal = '{10'h001, 10'h002, 10'h004};
    pats     = '{7'b1010101, 7'b0101010,
                 7'b0000000, 7'b1111111};
    exp_rs   = '{2'b10, 2'b00, 2'b01, 2'b11};

    #2;
    chk("rst_chal", 32'(chal), 0);
    chk("rst_crp_chal", 32'(crp_chal), 0);
    chk("rst_flags",
        {crp_valid, crp_resp, crp_stable, busy, done}, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // three CRPs, constant-1 response, ready always high
    puf_resp = 1'b1;
    crp_ready = 1'b1;
    d0 = done_cnt;
    start_run(10'h001, 16'd3);
    for (int i = 0; i < 3; i++) begin
      wait_valid(n);
      chk("lat", (i == 0) ? n + 1 : n, (i == 0) ? 24 : 23);
      chk("s1_chal", 32'(crp_chal), 32'(exp_chal[i]));
      chk("s1_rs", {crp_resp, crp_stable}, 2'b11);
      tick();
    end
    chk("s1_done", 32'(done), 1);
    tick();
    chk("s1_idle", {busy, done}, 0);
    chk("s1_done_cnt", done_cnt - d0, 1);

    // majority vote over controlled sample windows
    crp_ready = 1'b0;
    for (int p = 0; p < 4; p++) begin
      pat = pats[p];
      seed = 10'h011;
      num_chal = 16'd1;
      puf_resp = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= 23; k++) begin
        puf_resp = (k >= 15 && k <= 21) ? pat[k-15] : 1'b0;
        tick();
      end
      chk("s2_valid", 32'(crp_valid), 1);
      chk("s2_rs", {crp_resp, crp_stable}, 32'(exp_rs[p]));
      crp_ready = 1'b1;
      tick();
      tick();
      crp_ready = 1'b0;
    end

    // backpressure holds payload and challenge
    puf_resp = 1'b1;
    start_run(10'h155, 16'd2);
    wait_valid(n);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (!crp_valid || crp_chal !== 10'h155 ||
          chal !== 10'h155 ||
          {crp_resp, crp_stable} !== 2'b11)
        bad++;
      tick();
    end
    chk("s3_hold", bad, 0);
    crp_ready = 1'b1;
    tick();
    chk("s3_step", 32'(chal), 32'h2AB);
    chk("s3_vlow", 32'(crp_valid), 0);
    wait_valid(n);
    chk("s3_chal2", 32'(crp_chal), 32'h2AB);
    tick();
    chk("s3_done", 32'(done), 1);
    tick();

    // zero-length run; chal holds in idle
    d0 = done_cnt;
    start_run(10'h005, 16'd0);
    chk("s4_done", {done, crp_valid}, 2'b10);
    tick();
    chk("s4_idle", {busy, done}, 0);
    chk("s4_done_cnt", done_cnt - d0, 1);
    chk("s4_chal_hold", 32'(chal), 32'h2AB);

    // zero seed becomes 1
    start_run(10'h000, 16'd1);
    chk("s4_seed_chal", 32'(chal), 1);
    wait_valid(n);
    chk("s4_seed_crp", 32'(crp_chal), 1);
    tick();
    tick();

    // abort in SAMPLE
    d0 = done_cnt;
    crp_ready = 1'b0;
    start_run(10'h0AA, 16'd2);
    repeat (18) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_abort_s", {busy, crp_valid}, 0);
    repeat (3) tick();
    chk("s5_nodone_s", done_cnt - d0, 0);

    // abort on the handshake edge
    crp_ready = 1'b1;
    start_run(10'h0AA, 16'd2);
    wait_valid(n);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s5_abort_h", {busy, crp_valid}, 0);
    chk("s5_chal_h", 32'(chal), 32'h0AA);
    repeat (2) tick();
    chk("s5_nodone_h", done_cnt - d0, 0);

    start_run(10'h3FF, 16'd1);
    wait_valid(n);
    chk("s5_lat", n + 1, 24);
    chk("s5_chal", 32'(crp_chal), 32'h3FF);
    tick();
    chk("s5_done", 32'(done), 1);
    tick();

    // asynchronous reset mid-SETTLE
    start_run(10'h123, 16'd2);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("s6_flags",
        {crp_valid, crp_resp, crp_stable, busy, done}, 0);
    chk("s6_chal", 32'(chal), 0);
    chk("s6_crp_chal", 32'(crp_chal), 0);
    @(negedge clk);
    rst_n = 1'b1;
    seed = 10'h123;
    num_chal = 16'd1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("s6_restart", {busy, chal}, {1'b1, 10'h123});
    wait_valid(n);
    chk("s6_lat", n + 1, 24);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
